// File: rtl/pc_unit.sv
// Program-counter stage: PC, Z/N flags, branch-code decode and next-PC load.
// Also tracks misaligned redirect targets and counts taken redirects, saturating at all-ones.
module pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [2:0]       branch_cont,
  input  logic [15:0]      imm16,
  input  logic [25:0]      target26,
  input  logic [31:0]      rs_data,
  input  logic [31:0]      mem_rdata,
  input  logic             alu_zero,
  input  logic [31:0]      alu_result,
  input  logic             flag_we,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             flag_z,
  output logic             flag_n,
  output logic             taken,
  output logic             illegal,
  output logic             misalign,
  output logic [CNT_W-1:0] taken_cnt
);

  logic [31:0] tgt;
  logic [31:0] br_off;

  assign pc_plus4 = pc + 32'd4;
  assign br_off   = {{14{imm16[15]}}, imm16, 2'b00};

  // Flag conditions read the registered flags, never this cycle's update
  always_comb begin
    tgt     = pc_plus4;
    taken   = 1'b0;
    illegal = 1'b0;
    unique case (1'b1)
      (branch_cont == 3'b000): ;
      (branch_cont == 3'b001): begin
        taken = flag_z;
        tgt   = {pc_plus4[31:28], target26, 2'b00};
      end
      (branch_cont == 3'b010): begin
        taken = flag_n;
        tgt   = mem_rdata;
      end
      (branch_cont == 3'b100): begin
        taken = flag_z;
        tgt   = rs_data;
      end
      (branch_cont == 3'b101): begin
        taken = alu_zero;
        tgt   = pc_plus4 + br_off;
      end
      (branch_cont == 3'b110): begin
        taken = 1'b1;
        tgt   = mem_rdata;
      end
      default: illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc        <= RESET_PC;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      misalign  <= 1'b0;
      taken_cnt <= '0;
    end else if (!stall) begin
      pc       <= taken ? {tgt[31:2], 2'b00} : pc_plus4;
      misalign <= taken && (tgt[1:0] != 2'b00);
      if (flag_we) begin
        flag_z <= alu_zero;
        flag_n <= alu_result[31];
      end
      if (taken && (taken_cnt != {CNT_W{1'b1}}))
        taken_cnt <= taken_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios plus random codes, checked by a
// queue-based scoreboard against a behavioural next-PC model.
module tb_pc_unit;

  localparam int          CW  = 4;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          reset;
  logic          stall;
  logic [2:0]    bc;
  logic [15:0]   imm16;
  logic [25:0]   target26;
  logic [31:0]   rs_data;
  logic [31:0]   mem_rdata;
  logic          alu_zero;
  logic [31:0]   alu_result;
  logic          flag_we;
  logic [31:0]   pc;
  logic [31:0]   pc_plus4;
  logic          flag_z;
  logic          flag_n;
  logic          taken;
  logic          illegal;
  logic          misalign;
  logic [CW-1:0] taken_cnt;

  pc_unit #(.RESET_PC(RPC), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_cont(bc), .imm16(imm16), .target26(target26),
    .rs_data(rs_data), .mem_rdata(mem_rdata),
    .alu_zero(alu_zero), .alu_result(alu_result),
    .flag_we(flag_we), .pc(pc), .pc_plus4(pc_plus4),
    .flag_z(flag_z), .flag_n(flag_n), .taken(taken),
    .illegal(illegal), .misalign(misalign),
    .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   pc;
    logic          z;
    logic          n;
    logic          mis;
    logic [CW-1:0] cnt;
  } st_t;

  typedef struct {
    logic        taken;
    logic        illegal;
    logic [31:0] pp4;
  } cb_t;

  st_t sq[$];
  cb_t cq[$];
  int  total = 0;
  int  bad   = 0;

  // reference model state
  logic [31:0] m_pc;
  logic        m_z, m_n, m_mis;
  int          m_cnt;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : mon_comb
    cb_t e;
    if (cq.size() > 0) begin
      e = cq.pop_front();
      check("taken", {31'd0, taken}, {31'd0, e.taken});
      check("illegal", {31'd0, illegal}, {31'd0, e.illegal});
      check("pc_plus4", pc_plus4, e.pp4);
    end
  end

  always @(posedge clk) begin : mon_state
    st_t e;
    #1;
    if (sq.size() > 0) begin
      e = sq.pop_front();
      check("pc", pc, e.pc);
      check("flag_z", {31'd0, flag_z}, {31'd0, e.z});
      check("flag_n", {31'd0, flag_n}, {31'd0, e.n});
      check("misalign", {31'd0, misalign}, {31'd0, e.mis});
      check("taken_cnt", {28'd0, taken_cnt}, 32'(e.cnt));
    end
  end

  task automatic model_reset();
    m_pc  = RPC;
    m_z   = 1'b0;
    m_n   = 1'b0;
    m_mis = 1'b0;
    m_cnt = 0;
  endtask

  task automatic step(input logic s, input logic [2:0] c,
                      input logic [15:0] im, input logic [25:0] tg,
                      input logic [31:0] rs, input logic [31:0] mem,
                      input logic az, input logic [31:0] ar,
                      input logic fwe);
    logic [31:0] seq, dst;
    logic        go, ill;
    cb_t         ce;
    st_t         se;
    @(posedge clk);
    #2;
    stall = s; bc = c; imm16 = im; target26 = tg;
    rs_data = rs; mem_rdata = mem; alu_zero = az;
    alu_result = ar; flag_we = fwe;
    seq = m_pc + 32'd4;
    dst = seq;
    go  = 1'b0;
    ill = 1'b0;
    case (int'(c))
      1: begin go = m_z; dst = (seq & 32'hF000_0000) | (32'(tg) * 4); end
      2: begin go = m_n; dst = mem; end
      4: begin go = m_z; dst = rs; end
      5: begin go = az; dst = seq + 32'($signed(im)) * 4; end
      6: begin go = 1'b1; dst = mem; end
      3, 7: ill = 1'b1;
      default: ;
    endcase
    ce.taken = go; ce.illegal = ill; ce.pp4 = seq;
    cq.push_back(ce);
    if (!s) begin
      if (go) begin
        m_pc  = dst & ~32'd3;
        m_mis = (dst % 4) != 0;
        if (m_cnt < 15) m_cnt++;
      end else begin
        m_pc  = seq;
        m_mis = 1'b0;
      end
      if (fwe) begin
        m_z = az;
        m_n = ar[31];
      end
    end
    se.pc = m_pc; se.z = m_z; se.n = m_n; se.mis = m_mis;
    se.cnt = CW'(m_cnt);
    sq.push_back(se);
  endtask

  // wait for the last step's edge, then freeze the DUT for a direct look
  task automatic hold();
    @(posedge clk);
    #2;
    stall = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    stall = 1'b1;
    reset = 1'b1;
    #1;
    check("rst_pc", pc, RPC);
    check("rst_z", {31'd0, flag_z}, 32'd0);
    check("rst_n", {31'd0, flag_n}, 32'd0);
    check("rst_mis", {31'd0, misalign}, 32'd0);
    check("rst_cnt", {28'd0, taken_cnt}, 32'd0);
    model_reset();
    #2;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b1; bc = 3'd0; imm16 = '0;
    target26 = '0; rs_data = '0; mem_rdata = '0;
    alu_zero = 1'b0; alu_result = '0; flag_we = 1'b0;
    model_reset();
    #12;
    do_reset();

    repeat (3) step(0, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    hold();
    check("seq_pc12", pc, 32'd12);

    step(0, 3'b110, 0, 0, 0, 32'h40, 0, 0, 0);
    step(0, 3'b101, 16'hFFFF, 0, 0, 0, 1, 0, 0);
    step(0, 3'b101, 16'hFFFF, 0, 0, 0, 0, 0, 0);
    hold();
    check("beq_pc", pc, 32'h44);

    step(0, 3'b010, 0, 0, 0, 32'h200, 0, 32'h8000_0000, 1);
    step(0, 3'b010, 0, 0, 0, 32'h200, 0, 0, 0);
    hold();
    check("bmn_pc", pc, 32'h200);

    step(0, 3'b110, 0, 0, 0, 32'h1000_0010, 1, 0, 1);
    step(0, 3'b001, 0, 26'h100, 0, 0, 0, 0, 0);
    step(0, 3'b110, 0, 0, 0, 32'h123, 0, 0, 0);
    hold();
    check("jm_pc", pc, 32'h120);
    check("jm_mis", {31'd0, misalign}, 32'd1);

    step(0, 3'b011, 0, 0, 0, 32'h500, 1, 0, 0);
    step(1, 3'b110, 0, 0, 0, 32'h700, 1, 32'hFFFF_FFFF, 1);
    step(0, 3'b100, 0, 0, 32'h88, 0, 0, 0, 0);
    step(1, 3'b110, 0, 0, 0, 32'h900, 0, 0, 0);
    step(1, 3'b110, 0, 0, 0, 32'h904, 0, 0, 0);
    do_reset();

    repeat (18) step(0, 3'b110, 0, 0, 0, $urandom & ~32'd3, 0, 0, 0);
    hold();
    check("cnt_sat", {28'd0, taken_cnt}, 32'hF);
    step(0, 3'b110, 0, 0, 0, 32'hFFFF_FFFC, 0, 0, 0);
    step(0, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    hold();
    check("pc_wrap", pc, 32'd0);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] mem;
      mem = $urandom;
      if ($urandom_range(0, 1) == 0) mem[1:0] = 2'b00;
      step(($urandom_range(0, 7) == 0), 3'($urandom_range(0, 7)),
           16'($urandom), 26'($urandom), $urandom, mem,
           1'($urandom_range(0, 1)), $urandom,
           1'($urandom_range(0, 1)));
      if (i == 200) do_reset();
    end

    hold();
    @(posedge clk);
    #3;
    total++;
    if (sq.size() != 0 || cq.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", sq.size() + cq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
